// File: rtl/interp_pkg.sv
// Shared definitions for the linear interpolator: mode encoding, RATIO legality
// margin, divider FSM states and the remainder-width helper.
package interp_pkg;

   typedef enum logic {
      INTERP_MODE_LINEAR = 1'b0,
      INTERP_MODE_HOLD   = 1'b1
   } interp_mode_e;

   // RATIO must leave room for the serial divide (WIDTH+3 clocks) inside one frame
   localparam int INTERP_RATIO_MARGIN = 4;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_RUN,
      DIV_FIX
   } div_state_e;

   // Remainder accumulator holds values up to 2*RATIO-2 before wrapping
   function automatic int interp_rem_w(input int ratio);
      return $clog2(2 * ratio);
   endfunction

endpackage

// File: rtl/interp_lin_if.sv
// Sample-in / interpolated-out bus of interp_lin. The master drives samples and
// mode; the slave (the interpolator) returns in_ready and the output stream.
interface interp_lin_if #(parameter int WIDTH = 20);

   logic signed [WIDTH-1:0] in_data;
   logic                    in_valid;
   logic                    in_ready;
   logic                    mode;
   logic signed [WIDTH-1:0] interp_o;
   logic                    out_valid;

   modport master (output in_data, in_valid, mode,
                   input  in_ready, interp_o, out_valid);

   modport slave  (input  in_data, in_valid, mode,
                   output in_ready, interp_o, out_valid);

endinterface

// File: rtl/interp_div.sv
// Serial restoring divide of a signed dividend by the constant RATIO, floored:
// quot = floor(dividend/RATIO), 0 <= rmd < RATIO. Result valid WIDTH+3 clocks after start.
module interp_div import interp_pkg::*; #(
   parameter int WIDTH = 20,
   parameter int RATIO = 50,
   parameter int RW    = interp_rem_w(RATIO)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic signed [WIDTH:0] dividend,
   output logic signed [WIDTH:0] quot,
   output logic [RW-1:0]         rmd,
   output logic                  done
);

   localparam int N  = WIDTH + 1;
   localparam int CW = $clog2(N + 1);
   localparam logic [RW-1:0] R_V = RW'(RATIO);

   div_state_e state, state_nxt;
   logic          ld, st, fx;
   logic [N-1:0]  qs;
   logic [RW-1:0] pr;
   logic [RW-1:0] trial;
   logic          trial_ge;
   logic          neg;
   logic [CW-1:0] cnt;
   logic signed [WIDTH:0] mag;

   always_ff @(posedge clock) begin
      if (!reset) state <= DIV_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ld        = 1'b0;
      st        = 1'b0;
      fx        = 1'b0;
      case (state)
         DIV_IDLE: if (start) begin
            ld        = 1'b1;
            state_nxt = DIV_RUN;
         end
         DIV_RUN: begin
            st = 1'b1;
            if (cnt == CW'(N - 1)) state_nxt = DIV_FIX;
         end
         DIV_FIX: begin
            fx        = 1'b1;
            state_nxt = DIV_IDLE;
         end
         default: state_nxt = DIV_IDLE;
      endcase
   end

   // Partial remainder stays below RATIO, so the shifted trial fits in RW bits
   assign trial    = {pr[RW-2:0], qs[N-1]};
   assign trial_ge = (trial >= R_V);
   assign mag      = dividend[WIDTH] ? -dividend : dividend;

   always_ff @(posedge clock) begin
      if (!reset) begin
         qs   <= '0;
         pr   <= '0;
         neg  <= 1'b0;
         cnt  <= '0;
         quot <= '0;
         rmd  <= '0;
         done <= 1'b0;
      end else if (ld) begin
         qs   <= mag;
         pr   <= '0;
         neg  <= dividend[WIDTH];
         cnt  <= '0;
         done <= 1'b0;
      end else if (st) begin
         pr  <= trial_ge ? trial - R_V : trial;
         qs  <= {qs[N-2:0], trial_ge};
         cnt <= cnt + 1'b1;
      end else if (fx) begin
         // Floor correction: -uq-1 == ~uq, remainder folded back into [0,RATIO)
         if (neg) begin
            quot <= (pr == '0) ? -qs : ~qs;
            rmd  <= (pr == '0) ? '0 : R_V - pr;
         end else begin
            quot <= qs;
            rmd  <= pr;
         end
         done <= 1'b1;
      end
   end

endmodule

// File: rtl/interp_lin.sv
// Linear / zero-order-hold interpolator, RATIO output samples per input sample.
// Define INTERP_UNDERRUN_EN to add the sticky underrun output.
module interp_lin import interp_pkg::*; #(
   parameter int WIDTH = 20,
   parameter int RATIO = 50
) (
   input  logic         clock,
   input  logic         reset,
   interp_lin_if.slave  bus
`ifdef INTERP_UNDERRUN_EN
   ,
   output logic         underrun
`endif
);

   localparam int PW = $clog2(RATIO);
   localparam int RW = interp_rem_w(RATIO);
   localparam logic [RW-1:0] R_V = RW'(RATIO);

   if (RATIO < WIDTH + INTERP_RATIO_MARGIN) begin : g_ratio_chk
      $error("interp_lin: RATIO must be at least WIDTH+4");
   end

   logic [PW-1:0]         phase;
   logic                  last;
   logic signed [WIDTH-1:0] pend, seg_b, acc;
   logic                  pend_ok, b_ok, ov;
   interp_mode_e          mode_q;
   logic signed [WIDTH:0] q, div_q, dvd, sum_v;
   logic [RW-1:0]         r, rem, div_r, rem_sum;
   logic                  div_done, carry;

   assign last          = (phase == PW'(RATIO - 1));
   assign bus.in_ready  = last;
   assign bus.interp_o  = acc;
   assign bus.out_valid = ov;

   // pend is the sample to become the next endpoint; seg_b the current one
   assign dvd = {pend[WIDTH-1], pend} - {seg_b[WIDTH-1], seg_b};

   interp_div #(.WIDTH(WIDTH), .RATIO(RATIO), .RW(RW)) u_div (
      .clock   (clock),
      .reset   (reset),
      .start   (phase == '0),
      .dividend(dvd),
      .quot    (div_q),
      .rmd     (div_r),
      .done    (div_done)
   );

   assign rem_sum = rem + r;
   assign carry   = (rem_sum >= R_V);
   assign sum_v   = {acc[WIDTH-1], acc} + q + (WIDTH+1)'(carry);

   always_ff @(posedge clock) begin
      if (!reset) begin
         phase   <= '0;
         pend    <= '0;
         seg_b   <= '0;
         acc     <= '0;
         q       <= '0;
         r       <= '0;
         rem     <= '0;
         pend_ok <= 1'b0;
         b_ok    <= 1'b0;
         ov      <= 1'b0;
         mode_q  <= INTERP_MODE_LINEAR;
      end else if (last) begin
         // Frame boundary: old endpoint starts the next segment
         phase   <= '0;
         acc     <= seg_b;
         seg_b   <= pend;
         if (bus.in_valid) pend <= bus.in_data;
         q       <= div_done ? div_q : '0;
         r       <= div_done ? div_r : '0;
         rem     <= '0;
         pend_ok <= pend_ok | bus.in_valid;
         b_ok    <= pend_ok;
         ov      <= ov | (b_ok & pend_ok);
         mode_q  <= interp_mode_e'(bus.mode);
      end else begin
         phase <= phase + 1'b1;
         if (mode_q == INTERP_MODE_LINEAR) begin
            acc <= sum_v[WIDTH-1:0];
            rem <= carry ? rem_sum - R_V : rem_sum;
         end
      end
   end

`ifdef INTERP_UNDERRUN_EN
   always_ff @(posedge clock) begin
      if (!reset)
         underrun <= 1'b0;
      else if (last && !bus.in_valid && (ov || (b_ok && pend_ok)))
         underrun <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_interp_lin.sv
// Directed bench for interp_lin: a chained sample table exercising linear ramps,
// negative floors, hold mode with mid-frame toggles, underrun and mid-frame reset.
module tb_interp_lin;
   import interp_pkg::*;

   localparam int W  = 20;
   localparam int R  = 50;
   localparam int NF = 14;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   interp_lin_if #(.WIDTH(W)) bus();
`ifdef INTERP_UNDERRUN_EN
   logic underrun;
`endif

   interp_lin #(.WIDTH(W), .RATIO(R)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
`ifdef INTERP_UNDERRUN_EN
      ,
      .underrun(underrun)
`endif
   );

   int vecs = 0;
   int errs = 0;

   // Sample sent at the end of frame f, whether it is sent, and mode seen by frame f
   int s_tab[NF]  = '{0, 100, 0, 7, -1, -101, 5, 9, 10, 60, 0, 20, -3, 0};
   bit v_tab[NF]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1};
   bit md_tab[NF] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
   int eff[NF];

   function automatic int fdiv(input int n, input int d);
      int qq;
      qq = n / d;
      if ((n % d != 0) && (n < 0)) qq = qq - 1;
      return qq;
   endfunction

   task automatic chk(input string tag, input int obs, input int expv);
      vecs++;
      assert (obs === expv) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      int a, b, e;
      bus.in_data  = '0;
      bus.in_valid = 1'b0;
      bus.mode     = 1'b0;

      for (int f = 0; f < NF; f++)
         eff[f] = v_tab[f] ? s_tab[f] : ((f > 0) ? eff[f-1] : 0);

      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_interp_o", int'(bus.interp_o), 0);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_in_ready", int'(bus.in_ready), 0);
`ifdef INTERP_UNDERRUN_EN
      chk("rst_underrun", int'(underrun), 0);
`endif
      reset = 1'b1;

      for (int f = 0; f < NF; f++) begin
         for (int k = 0; k < R; k++) begin
            if (k == 20) bus.mode = (f + 1 < NF) ? md_tab[f+1] : 1'b0;
            if (f >= 3) begin
               a = eff[f-3];
               b = eff[f-2];
               e = md_tab[f] ? a : a + fdiv((b - a) * k, R);
               chk($sformatf("interp_o f%0d k%0d", f, k), int'(bus.interp_o), e);
            end
            chk($sformatf("out_valid f%0d k%0d", f, k), int'(bus.out_valid), (f >= 3) ? 1 : 0);
            if (k == 0 || k >= R - 2)
               chk($sformatf("in_ready f%0d k%0d", f, k), int'(bus.in_ready), (k == R - 1) ? 1 : 0);
`ifdef INTERP_UNDERRUN_EN
            chk($sformatf("underrun f%0d k%0d", f, k), int'(underrun), (f >= 11) ? 1 : 0);
`endif
            if (k == R - 1) begin
               bus.in_valid = v_tab[f];
               bus.in_data  = W'(s_tab[f]);
            end
            tick();
            bus.in_valid = 1'b0;
         end
      end

      // Reset asserted at phase 30 of an active segment
      repeat (30) tick();
      reset = 1'b0;
      tick();
      chk("midrst_interp_o", int'(bus.interp_o), 0);
      chk("midrst_out_valid", int'(bus.out_valid), 0);
      chk("midrst_in_ready", int'(bus.in_ready), 0);
`ifdef INTERP_UNDERRUN_EN
      chk("midrst_underrun", int'(underrun), 0);
`endif
      reset = 1'b1;
      repeat (R - 2) tick();
      chk("postrst_in_ready_early", int'(bus.in_ready), 0);
      tick();
      chk("postrst_in_ready_phase", int'(bus.in_ready), 1);
      chk("postrst_interp_o", int'(bus.interp_o), 0);
      chk("postrst_out_valid", int'(bus.out_valid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/interp_lin.md
INTERP_LIN -- requirements
Module: interp_lin

Interface
REQ-001 Parameter WIDTH, default 20: sample width, signed two's complement.
REQ-002 Parameter RATIO, default 50: output samples per input sample; legal range RATIO >= WIDTH+4, checked at elaboration.
REQ-003 clock  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 in_data  input  WIDTH  input sample, signed.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 mode  input  1  0 = linear interpolation, 1 = zero-order hold; sampled only at frame start.
REQ-009 interp_o  output  WIDTH  interpolated output, one sample per clock.
REQ-010 out_valid  output  1  interp_o carries interpolated data.
REQ-011 underrun  output  1  sticky underrun flag; present only with INTERP_UNDERRUN_EN.

Function
REQ-012 Phase counter runs 0..RATIO-1 and wraps to 0; one frame = RATIO clocks; no derived clocks.
REQ-013 in_ready is high only at phase RATIO-1; a transfer occurs when in_valid && in_ready.
REQ-014 Pipeline: a sample accepted at the end of frame n is divided during frame n+1 and becomes the segment endpoint b during frame n+2; the endpoint b of the current segment becomes the start point a of the next.
REQ-015 Divide stage computes d = b - a in WIDTH+1 bits, plus q = floor(d/RATIO) and r = d - q*RATIO with 0 <= r < RATIO (floor toward minus infinity, including for negative d).
REQ-016 Linear mode: at phase k, interp_o = a + floor(d*k/RATIO), exact with no approximation error; phase 0 outputs a exactly.
REQ-017 Linear update: interp_o += q and rem += r each clock; when rem >= RATIO, interp_o += 1 additionally and rem -= RATIO; rem clears at phase 0.
REQ-018 Hold mode: interp_o = a for all RATIO phases of the frame.
REQ-019 mode changes take effect only at the next phase 0; a mid-frame change is ignored for the current frame.
REQ-020 No in_valid at phase RATIO-1 (underrun): the last endpoint is repeated (d = 0) and the output stays flat for that segment.
REQ-021 out_valid rises at phase 0 of the first frame that has a segment built from two accepted samples; it then stays high until reset.
REQ-022 Intermediate sums use WIDTH+1 bits; results always lie between a and b inclusive, so interp_o never overflows WIDTH.

Reset
REQ-023 While reset is low at a clock edge: phase = 0, a = b = 0, q = r = rem = 0, interp_o = 0, out_valid = 0, in_ready = 0, underrun = 0, and the divider returns to idle.
REQ-024 Reset mid-frame aborts the segment and any division in progress; the first sample after release is treated as the first sample after power-up.

Configuration
REQ-025 With INTERP_UNDERRUN_EN defined, the underrun port exists and is set to 1 on any underrun once out_valid = 1; it clears only on reset.
REQ-026 Without INTERP_UNDERRUN_EN, the underrun port and its flop are absent; hold-on-underrun behaviour is unchanged.

Structure
REQ-027 The mode encoding (INTERP_MODE_LINEAR = 0, INTERP_MODE_HOLD = 1) and the minimum-RATIO check constant live in shared package interp_pkg.
REQ-028 Division lives in sub-module interp_div: a serial restoring divider of signed dividend by constant RATIO with floor correction, start/done handshake, and done within WIDTH+3 clocks.

Verification
REQ-029 RATIO=50, samples 0 then 100, linear: segment outputs 0,2,4,...,98, and the next phase 0 outputs 100.
REQ-030 Samples 0 then 7: interp_o at phase k equals floor(7k/50); the first step to 1 occurs at k=8; exact match on all 50 values.
REQ-031 Samples -1 then -101: outputs -1,-3,...,-99, then -101; checks floor of negative d.
REQ-032 mode=1, samples 5 then 9: 50 outputs of 5, then 9; mode toggled at phase 20 has no effect until phase 0.
REQ-033 in_valid dropped for one frame after samples 10 and 60: the segment after 60 is flat at 60, and underrun=1 (macro on) until reset.
REQ-034 reset low at phase 30 of an active segment: next cycle interp_o=0, out_valid=0, phase=0, underrun=0.
